// File: rtl/output_port_scheduler_if.sv
// Handshake bundle between the five input ports and one output-port scheduler.
// master drives requests, flits and credits; slave is the scheduler.
interface output_port_scheduler_if #(
    parameter int NPORTS  = 5,
    parameter int LEN_W   = 8,
    parameter int CREDITS = 4
) ();
    localparam int CNT_W = $clog2(CREDITS + 1);

    logic [NPORTS-1:0]       req;
    logic [NPORTS*LEN_W-1:0] req_len;
    logic [NPORTS-1:0]       in_valid;
    logic [NPORTS-1:0]       in_ready;
    logic                    credit_in;
    logic [NPORTS-1:0]       grant;
    logic [2:0]              out_sel;
    logic                    out_valid;
    logic                    busy;
    logic [CNT_W-1:0]        credit_cnt;
    logic                    credit_err;

    modport master (
        output req, req_len, in_valid, credit_in,
        input  in_ready, grant, out_sel, out_valid, busy, credit_cnt, credit_err
    );

    modport slave (
        input  req, req_len, in_valid, credit_in,
        output in_ready, grant, out_sel, out_valid, busy, credit_cnt, credit_err
    );
endinterface

// File: rtl/output_port_scheduler.sv
// Round-robin, packet-locked output-port scheduler with downstream credit flow control.
// One lane instance per input port handles length normalisation and flit accept.
module output_port_scheduler_lane #(
    parameter int LEN_W = 8
) (
    input  logic [LEN_W-1:0] len,
    input  logic             own,
    input  logic             xfer,
    output logic [LEN_W-1:0] len_eff,
    output logic             ready
);
    // A zero-length request still moves one flit.
    assign len_eff = (len == '0) ? LEN_W'(1) : len;
    assign ready   = own & xfer;
endmodule

module output_port_scheduler #(
    parameter int NPORTS  = 5,
    parameter int CREDITS = 4,
    parameter int LEN_W   = 8
) (
    input logic clock,
    input logic reset,
    output_port_scheduler_if.slave bus
);
    localparam int CNT_W = $clog2(CREDITS + 1);

    typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;

    state_t                        state, state_nxt;
    logic [NPORTS-1:0]             grant;
    logic [2:0]                    out_sel;
    logic [2:0]                    ptr;
    logic [LEN_W-1:0]              rem;
    logic [CNT_W-1:0]              credit_cnt;
    logic                          credit_err;

    logic [NPORTS-1:0][LEN_W-1:0]  len_eff;
    logic [NPORTS-1:0]             in_ready;
    logic [2:0]                    pick;
    logic                          found;
    int                            idx;
    logic                          xfer;
    logic                          last;

    assign xfer = (state == XFER) && bus.in_valid[out_sel] && (credit_cnt != '0);
    assign last = xfer && (rem == LEN_W'(1));

    genvar p;
    generate
        for (p = 0; p < NPORTS; p++) begin : g_lane
            output_port_scheduler_lane #(.LEN_W(LEN_W)) u_lane (
                .len     (bus.req_len[p*LEN_W +: LEN_W]),
                .own     (grant[p]),
                .xfer    (xfer),
                .len_eff (len_eff[p]),
                .ready   (in_ready[p])
            );
        end
    endgenerate

    // Scan starts one past the last owner so every port gets a turn.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NPORTS; i++) begin
            idx = (int'(ptr) + i) % NPORTS;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = 3'(idx);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = XFER;
            XFER:    if (last)  state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant   <= '0;
            out_sel <= '0;
            ptr     <= 3'(NPORTS - 1);
            rem     <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    grant   <= NPORTS'(1) << pick;
                    out_sel <= pick;
                    rem     <= len_eff[pick];
                end
                XFER: if (xfer) begin
                    rem <= rem - LEN_W'(1);
                    if (last) grant <= '0;
                end
                RELEASE: ptr <= out_sel;
                default: grant <= '0;
            endcase
        end
    end

    // Simultaneous consume and return leave the count unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            credit_cnt <= CNT_W'(CREDITS);
            credit_err <= 1'b0;
        end else if (bus.credit_in && !xfer) begin
            if (credit_cnt == CNT_W'(CREDITS)) credit_err <= 1'b1;
            else                               credit_cnt <= credit_cnt + CNT_W'(1);
        end else if (xfer && !bus.credit_in) begin
            credit_cnt <= credit_cnt - CNT_W'(1);
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.grant      = grant;
    assign bus.out_sel    = out_sel;
    assign bus.out_valid  = xfer;
    assign bus.busy       = (state != IDLE);
    assign bus.credit_cnt = credit_cnt;
    assign bus.credit_err = credit_err;
endmodule

// File: tb/tb_output_port_scheduler.sv
// Directed bench for output_port_scheduler: grant locking, round-robin order,
// credit stall/overflow and asynchronous reset mid-packet.
module tb_output_port_scheduler;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   xfers;
    int   budget;

    always #5 clock = ~clock;

    output_port_scheduler_if #(.NPORTS(5), .LEN_W(8), .CREDITS(4)) bus ();

    output_port_scheduler #(.NPORTS(5), .CREDITS(4), .LEN_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req = '0; bus.req_len = '0; bus.in_valid = '0; bus.credit_in = 1'b0;
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        bus.req = '0; bus.req_len = '0; bus.in_valid = '0; bus.credit_in = 1'b0;

        // reset state
        do_reset();
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_sel", 32'(bus.out_sel), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_cnt", 32'(bus.credit_cnt), 4);
        chk("rst_err", 32'(bus.credit_err), 0);
        chk("rst_ready", 32'(bus.in_ready), 0);
        chk("rst_ovalid", 32'(bus.out_valid), 0);

        // single 3-flit packet from LOCAL
        bus.req = 5'b00001; bus.req_len[7:0] = 8'd3; bus.in_valid = 5'b00001;
        tick();
        bus.req = '0;
        #1;
        chk("t1_grant", 32'(bus.grant), 1);
        chk("t1_ready", 32'(bus.in_ready), 1);
        chk("t1_busy", 32'(bus.busy), 1);
        xfers = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.grant == '0) break;
            chk("t1_grant_held", 32'(bus.grant), 1);
            if (bus.out_valid) xfers++;
            tick();
        end
        chk("t1_xfers", 32'(xfers), 3);
        chk("t1_rel_busy", 32'(bus.busy), 1);
        chk("t1_rel_ovalid", 32'(bus.out_valid), 0);
        chk("t1_cnt", 32'(bus.credit_cnt), 1);
        tick();
        chk("t1_idle_busy", 32'(bus.busy), 0);
        chk("t1_idle_grant", 32'(bus.grant), 0);

        // round robin, all ports requesting, credits returned each flit
        do_reset();
        bus.req = 5'b11111; bus.req_len = '0;
        for (int p = 0; p < 5; p++) bus.req_len[p*8 +: 8] = 8'd1;
        bus.in_valid = 5'b11111;
        #1;
        for (int k = 0; k < 6; k++) begin
            budget = 0;
            while (bus.grant == '0 && budget < 10) begin
                tick();
                budget++;
            end
            chk("rr_timeout", 32'(budget < 10), 1);
            chk("rr_grant", 32'(bus.grant), 32'(1) << (k % 5));
            chk("rr_sel", 32'(bus.out_sel), 32'(k % 5));
            chk("rr_ovalid", 32'(bus.out_valid), 1);
            bus.credit_in = 1'b1;
            tick();
            bus.credit_in = 1'b0;
            #1;
        end
        chk("rr_cnt", 32'(bus.credit_cnt), 4);
        chk("rr_err", 32'(bus.credit_err), 0);

        // zero-credit stall, one credit releases exactly one flit
        do_reset();
        bus.req = 5'b00001; bus.req_len[7:0] = 8'd6; bus.in_valid = 5'b00001;
        tick();
        bus.req = '0;
        #1;
        xfers = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.out_valid) xfers++;
            tick();
        end
        chk("zc_xfers", 32'(xfers), 4);
        chk("zc_cnt", 32'(bus.credit_cnt), 0);
        chk("zc_ready", 32'(bus.in_ready), 0);
        chk("zc_grant", 32'(bus.grant), 1);
        bus.credit_in = 1'b1;
        tick();
        bus.credit_in = 1'b0;
        #1;
        chk("zc_one_ovalid", 32'(bus.out_valid), 1);
        tick();
        chk("zc_restall", 32'(bus.out_valid), 0);
        chk("zc_grant2", 32'(bus.grant), 1);

        // WEST packet: foreign in_valid ignored, simultaneous credit/xfer
        do_reset();
        bus.req = 5'b00100; bus.req_len[23:16] = 8'd10;
        tick();
        bus.req = '0;
        #1;
        chk("w_grant", 32'(bus.grant), 4);
        chk("w_sel", 32'(bus.out_sel), 2);
        chk("w_noval", 32'(bus.out_valid), 0);
        bus.in_valid = 5'b11111;
        #1;
        chk("w_ready", 32'(bus.in_ready), 32'b00100);
        tick();
        tick();
        chk("w_cnt2", 32'(bus.credit_cnt), 2);
        bus.credit_in = 1'b1;
        #1;
        chk("w_both_ovalid", 32'(bus.out_valid), 1);
        tick();
        bus.credit_in = 1'b0; bus.in_valid = '0;
        #1;
        chk("w_both_cnt", 32'(bus.credit_cnt), 2);

        // credit overflow
        bus.credit_in = 1'b1;
        tick();
        tick();
        chk("ov_cnt_full", 32'(bus.credit_cnt), 4);
        chk("ov_err_pre", 32'(bus.credit_err), 0);
        tick();
        bus.credit_in = 1'b0;
        #1;
        chk("ov_cnt", 32'(bus.credit_cnt), 4);
        chk("ov_err", 32'(bus.credit_err), 1);
        tick();
        chk("ov_err_sticky", 32'(bus.credit_err), 1);

        // drain to rem=3, then asynchronous reset
        bus.in_valid = 5'b00100;
        for (int c = 0; c < 4; c++) tick();
        chk("mr_cnt", 32'(bus.credit_cnt), 0);
        chk("mr_grant", 32'(bus.grant), 4);
        reset = 1'b1;
        #1;
        chk("mr_grant0", 32'(bus.grant), 0);
        chk("mr_cnt4", 32'(bus.credit_cnt), 4);
        chk("mr_err0", 32'(bus.credit_err), 0);
        chk("mr_busy0", 32'(bus.busy), 0);
        chk("mr_ready0", 32'(bus.in_ready), 0);
        reset = 1'b0;
        bus.in_valid = '0;
        bus.req = 5'b11111;
        tick();
        chk("mr_local", 32'(bus.grant), 1);
        bus.req = '0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
